tcm_mem_port_ctrl: RTL
======================

Name: tcm_mem_port_ctrl

Overview:
- Initiator-side controller for the 64-bit single-port TCM RAM: 1-cycle read latency, 8 byte write enables, 14-bit word address.
- Accepts 32-bit core data-port requests on a valid/accept interface and maps them onto the RAM's 64-bit lanes.
- Returns in-order responses, with tag, through a response FIFO that honours back-pressure.
- Sits between the core LSU/fetch port and the TCM RAM instance.

Parameters:
- TCM_BASE, 32'h8000_0000, byte base address of the TCM window.
- TCM_ADDR_W, 17, log2 of window size in bytes (128KB); RAM word index = addr[TCM_ADDR_W-1:3].
- TAG_W, 11, request/response tag width.
- RESP_DEPTH, 4, response FIFO entries (min 2; full 1/cycle throughput needs >=3).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- req_rd_i  in  1  read request.
- req_wr_i  in  4  byte write strobes (non-zero = write).
- req_addr_i  in  32  byte address.
- req_data_wr_i  in  32  write data.
- req_tag_i  in  TAG_W  request tag.
- req_accept_o  out  1  request taken this cycle when (req_rd_i | |req_wr_i) & req_accept_o.
- resp_ack_o  out  1  response valid.
- resp_data_rd_o  out  32  read data (0 for writes and errors).
- resp_tag_o  out  TAG_W  tag of the response.
- resp_error_o  out  1  out-of-window access.
- resp_ready_i  in  1  response consumer ready.
- ram_addr_o  out  14  RAM word address.
- ram_data_o  out  64  RAM write data.
- ram_wr_o  out  8  RAM byte write enables.
- ram_data_i  in  64  RAM read data, valid one cycle after the address.

Behaviour:
- Reset: req_accept_o=0, resp_ack_o=0, resp_data_rd_o=0, resp_tag_o=0, resp_error_o=0, ram_wr_o=0 while rst_i=1. Stage-1 register and FIFO are cleared. RAM contents are not touched. Requests in flight at reset are dropped with no response.
- Occupancy = FIFO count + stage-1 valid. req_accept_o = !rst_i & (occupancy < RESP_DEPTH), registered-count based, so it is independent of req_* in the same cycle.
- Accept cycle N, combinational to RAM:
  - ram_addr_o = req_addr_i[TCM_ADDR_W-1:3].
  - ram_data_o = {req_data_wr_i, req_data_wr_i}.
  - ram_wr_o = addr[2] ? {req_wr_i, 4'b0} : {4'b0, req_wr_i}, gated by accept and in-window.
  - With no accepted write, ram_wr_o=0. ram_addr_o still follows req_addr_i (harmless read).
- In-window: (req_addr_i - TCM_BASE) < 2^TCM_ADDR_W, unsigned. Out-of-window: ram_wr_o=0; response carries error=1, data=0.
- req_rd_i and req_wr_i both set: treated as write; response data=0.
- Stage 1 (cycle N+1) holds valid, tag, addr[2], is_read, error.
  - Read data = addr[2] ? ram_data_i[63:32] : ram_data_i[31:0].
  - The entry is pushed into the FIFO at the end of N+1.
- FIFO head drives resp_* as registered outputs. First response appears at N+2 (fixed 2-cycle min latency).
- Pop on resp_ack_o & resp_ready_i. Push and pop in the same cycle are legal, count unchanged. Pointers wrap modulo RESP_DEPTH.
- Responses are strictly in request order. resp_* stay stable while resp_ack_o=1 & !resp_ready_i.
- FIFO full is impossible by construction (accept gated on occupancy). Overflow is an assertion failure.
- Read-after-write to the same word on back-to-back cycles returns the new data (RAM write at N, read at N+1).

Decomposition:
- Package tcm_pkg holds TCM_BASE/TCM_ADDR_W defaults, RAM word/byte-enable widths (64/8), and a resp_entry typedef {tag, data, error}.
- Sub-module tcm_resp_fifo: parameterised synchronous FIFO with count output, async active-high reset.

Test Plan:
- Write 0xDEADBEEF, strobes 4'hF, to 0x8000_0004, then read 0x8000_0004 -> ram_wr_o=8'hF0 in the write cycle; read response data 0xDEADBEEF, correct tag, error=0, ack 2 cycles after accept.
- Write 0x11 with strobe 4'h1 to 0x8000_0000 over a preloaded 0xAABBCCDD, then read -> 0xAABBCC11; upper half-word unchanged.
- Read 0x8002_0000 (just past window) -> ram_wr_o=0; error=1, data=0, tag echoed.
- Issue 6 back-to-back reads with resp_ready_i=0 -> req_accept_o drops after 4 accepts. Raise ready -> 4 responses in order, then remaining 2 accepted and returned in order.
- Stream reads with resp_ready_i=1 -> one accept and one ack per cycle, no bubbles after fill.
- Assert rst_i mid-stream with 3 pending -> all outputs 0 immediately; no stale acks after release; a new read returns correctly.

Source files
------------

// File: rtl/tcm_mem_port_ctrl_pkg.sv
// Shared constants and types for the TCM data-port controller.
package tcm_pkg;

    localparam logic [31:0] TCM_BASE_DEF   = 32'h8000_0000;
    localparam int unsigned TCM_ADDR_W_DEF = 17;
    localparam int unsigned TAG_W_DEF      = 11;
    localparam int unsigned RAM_DATA_W     = 64;
    localparam int unsigned RAM_BE_W       = 8;

    typedef struct packed {
        logic [TAG_W_DEF-1:0] tag;
        logic [31:0]          data;
        logic                 error;
    } resp_entry_t;

    // Place 32-bit byte strobes onto the 64-bit RAM word half picked by addr[2].
    function automatic logic [RAM_BE_W-1:0] lane_be(input logic [3:0] strb, input logic hi);
        return hi ? {strb, 4'b0000} : {4'b0000, strb};
    endfunction

endpackage

// File: rtl/tcm_mem_port_ctrl_if.sv
// Core-side request/response bundle of the TCM port controller.
interface tcm_mem_port_ctrl_if #(
    parameter int unsigned TAG_W = tcm_pkg::TAG_W_DEF
);
    logic             req_rd_i;
    logic [3:0]       req_wr_i;
    logic [31:0]      req_addr_i;
    logic [31:0]      req_data_wr_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             req_accept_o;
    logic             resp_ack_o;
    logic [31:0]      resp_data_rd_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic             resp_error_o;
    logic             resp_ready_i;

    modport master (
        output req_rd_i, req_wr_i, req_addr_i, req_data_wr_i, req_tag_i, resp_ready_i,
        input  req_accept_o, resp_ack_o, resp_data_rd_o, resp_tag_o, resp_error_o
    );

    modport slave (
        input  req_rd_i, req_wr_i, req_addr_i, req_data_wr_i, req_tag_i, resp_ready_i,
        output req_accept_o, resp_ack_o, resp_data_rd_o, resp_tag_o, resp_error_o
    );
endinterface

// File: rtl/tcm_mem_port_ctrl_resp_fifo.sv
// Synchronous FIFO with occupancy count; head entry is presented from registers.
module tcm_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 44
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_i && !do_pop && count_q == CNT_W'(DEPTH)));
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/tcm_mem_port_ctrl.sv
// Maps 32-bit core data-port requests onto the 64-bit single-port TCM RAM and
// returns in-order tagged responses through a back-pressured response FIFO.
module tcm_mem_port_ctrl
    import tcm_pkg::*;
#(
    parameter logic [31:0] TCM_BASE   = TCM_BASE_DEF,
    parameter int unsigned TCM_ADDR_W = TCM_ADDR_W_DEF,
    parameter int unsigned TAG_W      = TAG_W_DEF,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    tcm_mem_port_ctrl_if.slave       core,
    output logic [TCM_ADDR_W-4:0]    ram_addr_o,
    output logic [RAM_DATA_W-1:0]    ram_data_o,
    output logic [RAM_BE_W-1:0]      ram_wr_o,
    input  logic [RAM_DATA_W-1:0]    ram_data_i
);
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH+1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             error;
    } entry_t;

    logic [31:0]      offset;
    logic             in_win, is_wr, req_v, accept, take;
    logic [CNT_W:0]   occ;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_valid;
    entry_t           push_entry, head_entry;

    logic             s1_valid_q, s1_valid_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic             s1_hi_q,    s1_hi_d;
    logic             s1_rd_q,    s1_rd_d;
    logic             s1_err_q,   s1_err_d;

    always_comb begin
        offset = core.req_addr_i - TCM_BASE;
        in_win = ({1'b0, offset} < (33'd1 << TCM_ADDR_W));
        is_wr  = (core.req_wr_i != 4'b0000);
        req_v  = core.req_rd_i || is_wr;
        // Stage-1 entry counts as occupied so its FIFO push can never overflow.
        occ    = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, s1_valid_q};
        accept = !rst_i && (occ < (CNT_W+1)'(RESP_DEPTH));
        take   = req_v && accept;

        ram_addr_o = core.req_addr_i[TCM_ADDR_W-1:3];
        ram_data_o = {core.req_data_wr_i, core.req_data_wr_i};
        ram_wr_o   = (take && in_win && is_wr) ? lane_be(core.req_wr_i, core.req_addr_i[2]) : '0;

        s1_valid_d = take;
        s1_tag_d   = core.req_tag_i;
        s1_hi_d    = core.req_addr_i[2];
        s1_rd_d    = !is_wr;
        s1_err_d   = !in_win;

        push_entry.tag   = s1_tag_q;
        push_entry.error = s1_err_q;
        push_entry.data  = '0;
        if (s1_rd_q && !s1_err_q) begin
            push_entry.data = s1_hi_q ? ram_data_i[63:32] : ram_data_i[31:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            s1_hi_q    <= 1'b0;
            s1_rd_q    <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            s1_hi_q    <= s1_hi_d;
            s1_rd_q    <= s1_rd_d;
            s1_err_q   <= s1_err_d;
        end
    end

    tcm_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (s1_valid_q),
        .data_i  (push_entry),
        .pop_i   (core.resp_ready_i),
        .valid_o (fifo_valid),
        .data_o  (head_entry),
        .count_o (fifo_cnt)
    );

    assign core.req_accept_o   = accept;
    assign core.resp_ack_o     = fifo_valid;
    assign core.resp_data_rd_o = head_entry.data;
    assign core.resp_tag_o     = head_entry.tag;
    assign core.resp_error_o   = head_entry.error;

endmodule
